// File: rtl/lsu_axi_master.sv
// lsu_axi_master
// Bridges single load/store requests from a core onto an AXI-lite master
// port, keeping one transaction outstanding at a time.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_*                     core request channel (valid/ready, we, addr, wdata, wstrb)
//   resp_*                    core response channel (valid/ready, rdata, err)
//   ar*/r*                    AXI-lite read address / read data channels
//   aw*/w*/b*                 AXI-lite write address / write data / write response channels
//
// All handshake outputs are decoded from the state register and the
// aw_done/w_done flags only, so no *_ready_i/*_valid_i input reaches any
// *_valid_o output combinationally.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_done;
    logic              w_done;
    logic              aw_ok;
    logic              w_ok;

    // A channel counts as complete if it finished earlier or handshakes now.
    assign aw_ok = aw_done || awready_i;
    assign w_ok  = w_done  || wready_i;

    // req_ready is gated by rst so it reads 0 while reset is held, and 1 in
    // the very first cycle after release (state is already IDLE).
    assign req_ready_o  = (state == IDLE) && !rst;
    assign arvalid_o    = (state == RD_ADDR);
    assign rready_o     = (state == RD_DATA);
    assign awvalid_o    = (state == WR_REQ) && !aw_done;
    assign wvalid_o     = (state == WR_REQ) && !w_done;
    assign bready_o     = (state == WR_RESP);
    assign resp_valid_o = (state == RESP);

    assign araddr_o = addr_q;
    assign awaddr_o = addr_q;
    assign wdata_o  = wdata_q;
    assign wstrb_o  = wstrb_q;

    // The read/write direction is carried by the state itself, so no
    // separate we register is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        wstrb_q <= req_wstrb_i;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= req_we_i ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (arready_i) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rvalid_i) begin
                        resp_rdata_o <= rdata_i;
                        resp_err_o   <= (rresp_i != 2'b00);
                        state        <= RESP;
                    end
                end
                WR_REQ: begin
                    if (aw_ok && w_ok) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        aw_done <= aw_ok;
                        w_done  <= w_ok;
                    end
                end
                WR_RESP: begin
                    if (bvalid_i) begin
                        resp_rdata_o <= '0;
                        resp_err_o   <= (bresp_i != 2'b00);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Testbench for lsu_axi_master: directed scenarios followed by randomized
// transactions against a slave whose wait states are chosen per transaction.
// Expected latencies, handshake counts and response values are computed from
// the chosen wait states with plain arithmetic.
module tb_lsu_axi_master;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_wstrb_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [63:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] awaddr_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [63:0] wdata_o;
    logic [7:0]  wstrb_o;
    logic        wvalid_o;
    logic        wready_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i;
    logic        bready_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(64), .STRB_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 0);
        chk({tag, "_handshake"}, {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid_o}, 0);
        chk({tag, "_resp"}, {resp_rdata_o, resp_err_o}, 0);
        chk({tag, "_latched"}, {araddr_o, wdata_o, wstrb_o}, 0);
    endtask

    // Runs one transaction starting between a negedge and the next posedge.
    // Slave waits: aw/w/ar = cycles of valid before ready, r/b = cycles of
    // ready before valid, bp = cycles resp_valid is held before resp_ready.
    // While not being handshaked, rvalid/bvalid are driven high with junk so
    // that any sampling outside RD_DATA/WR_RESP corrupts the response.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                           input logic [7:0] ws, input int arw, input int rw, input int aww,
                           input int ww, input int bw, input int bpw,
                           input logic [63:0] sd, input logic [1:0] sr);
        int c = 0, ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0, rv_n = 0;
        int rv_first = -1, rr_first = -1, br_first = -1, lat_exp, mx;
        bit done = 0;
        logic [63:0] exp_d;
        exp_d   = we ? 64'd0 : sd;
        mx      = (aww > ww) ? aww : ww;
        lat_exp = we ? (3 + mx + bw) : (3 + arw + rw);

        chk("accept_ready", req_ready_o, 1);
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_wstrb_i = ws;
        while (!done && c < 300) begin
            @(posedge clk); @(negedge clk); c++;
            req_valid_i = 0; req_addr_i = $urandom; req_wdata_i = {$urandom, $urandom};
            req_wstrb_i = 8'($urandom);
            arready_i = 0; awready_i = 0; wready_i = 0; resp_ready_i = 0;
            rvalid_i = 1; rdata_i = 64'hdead_beef_0bad_f00d; rresp_i = 2'b11;
            bvalid_i = 1; bresp_i = 2'b11;
            chk("busy_no_ready", req_ready_o, 0);
            if (arvalid_o) begin
                chk("araddr", araddr_o, addr);
                arready_i = (ar_n == arw);
                ar_n++;
            end
            if (awvalid_o) begin
                chk("awaddr", awaddr_o, addr);
                awready_i = (aw_n == aww);
                aw_n++;
            end
            if (wvalid_o) begin
                chk("wdata", {wdata_o, wstrb_o}, {wd, ws});
                wready_i = (w_n == ww);
                w_n++;
            end
            if (rready_o) begin
                if (rr_first < 0) rr_first = c;
                rvalid_i = (r_n == rw); rdata_i = sd; rresp_i = sr;
                r_n++;
            end
            if (bready_o) begin
                if (br_first < 0) br_first = c;
                bvalid_i = (b_n == bw); bresp_i = sr;
                b_n++;
            end
            if (resp_valid_o) begin
                if (rv_first < 0) rv_first = c;
                chk("resp_data", {resp_rdata_o, resp_err_o}, {exp_d, sr != 2'b00});
                resp_ready_i = (rv_n == bpw);
                done = (rv_n == bpw);
                rv_n++;
            end
        end
        chk("no_timeout", done, 1);
        chk("latency", rv_first, lat_exp);
        chk("resp_hold", rv_n, bpw + 1);
        chk("ar_cycles", ar_n, we ? 0 : arw + 1);
        chk("r_cycles", r_n, we ? 0 : rw + 1);
        chk("aw_cycles", aw_n, we ? aww + 1 : 0);
        chk("w_cycles", w_n, we ? ww + 1 : 0);
        chk("b_cycles", b_n, we ? bw + 1 : 0);
        if (we) chk("bready_first", br_first, 2 + mx);
        else    chk("rready_first", rr_first, 2 + arw);
        @(posedge clk); @(negedge clk);
        resp_ready_i = 0;
        chk("back_idle", {req_ready_o, resp_valid_o, arvalid_o, awvalid_o, wvalid_o}, 5'b10000);
    endtask

    initial begin
        rst = 1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0; req_wstrb_i = 0;
        resp_ready_i = 0; arready_i = 0; rdata_i = 0; rresp_i = 0; rvalid_i = 0;
        awready_i = 0; wready_i = 0; bresp_i = 0; bvalid_i = 0;
        repeat (2) @(negedge clk);
        chk_all_quiet("reset");
        rst = 0;
        #1 chk("release_ready", req_ready_o, 1);

        // Zero-wait read: 0xa000_03f8 returns 0x41.
        run_txn(0, 32'ha000_03f8, 64'd0, 8'h00, 0, 0, 0, 0, 0, 0, 64'h41, 2'b00);
        // Write, awready three cycles late, wready immediate.
        run_txn(1, 32'h0000_1000, 64'h48, 8'h01, 0, 0, 3, 0, 0, 0, 64'h0, 2'b00);
        // Write, wready late, awready immediate, SLVERR response.
        run_txn(1, 32'h0000_2008, 64'h1122_3344_5566_7788, 8'hf0, 0, 0, 0, 3, 1, 0, 64'h0, 2'b10);
        // Response back-pressure for five cycles.
        run_txn(0, 32'h0000_3000, 64'd0, 8'h00, 1, 2, 0, 0, 0, 5, 64'hcafe_f00d_1234_5678, 2'b00);

        // Reset pulse while waiting in RD_DATA with rvalid never asserted.
        req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h0000_4440;
        @(posedge clk); @(negedge clk);
        req_valid_i = 0; arready_i = 1; rvalid_i = 0; bvalid_i = 0;
        @(posedge clk); @(negedge clk);
        arready_i = 0;
        chk("rd_data_rready", rready_o, 1);
        @(posedge clk); #2;
        rst = 1;
        #1 chk_all_quiet("mid_reset");
        @(negedge clk);
        rst = 0;
        #1 chk("post_reset_ready", req_ready_o, 1);
        run_txn(0, 32'h0000_4448, 64'd0, 8'h00, 0, 1, 0, 0, 0, 1, 64'h5a5a_0000_ffff_0001, 2'b00);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    {$urandom, $urandom}, 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 64, data width; STRB_W, DATA_W/8, write-strobe width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  master can accept a request.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  ADDR_W  request address.
- req_wdata_i  in  DATA_W  write data.
- req_wstrb_i  in  STRB_W  write byte strobes.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  core accepts response.
- resp_rdata_o  out  DATA_W  read data; 0 for writes.
- resp_err_o  out  1  1 if RRESP/BRESP != 2'b00.
- araddr_o  out  ADDR_W  AXI-lite read address.
- arvalid_o  out  1  read address valid.
- arready_i  in  1  read address ready.
- rdata_i  in  DATA_W  read data.
- rresp_i  in  2  read response.
- rvalid_i  in  1  read data valid.
- rready_o  out  1  read data ready.
- awaddr_o  out  ADDR_W  write address.
- awvalid_o  out  1  write address valid.
- awready_i  in  1  write address ready.
- wdata_o  out  DATA_W  write data.
- wstrb_o  out  STRB_W  write strobes.
- wvalid_o  out  1  write data valid.
- wready_i  in  1  write data ready.
- bresp_i  in  2  write response.
- bvalid_i  in  1  write response valid.
- bready_o  out  1  write response ready.

Function
REQ-003 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP; one transaction outstanding at a time.
REQ-004 SHALL drive req_ready_o=1 only in IDLE; a request is accepted on req_valid_i && req_ready_o.
REQ-005 On accept, SHALL latch addr/we/wdata/wstrb; IDLE->RD_ADDR if we=0, IDLE->WR_REQ if we=1.
REQ-006 Latched address/data/strobes SHALL drive araddr_o/awaddr_o/wdata_o/wstrb_o and stay stable while the corresponding valid is high.
REQ-007 RD_ADDR: arvalid_o=1 until arvalid_o && arready_i, then ->RD_DATA next cycle; arvalid_o SHALL NOT depend on arready_i.
REQ-008 RD_DATA: rready_o=1; on rvalid_i SHALL capture rdata_i into resp_rdata_o and (rresp_i!=0) into resp_err_o, ->RESP.
REQ-009 WR_REQ: awvalid_o and wvalid_o both asserted on entry; each SHALL deassert independently after its own handshake, tracked by aw_done/w_done flags.
REQ-010 WR_REQ->WR_RESP in the cycle after both handshakes complete, whether simultaneous or in either order.
REQ-011 WR_RESP: bready_o=1; on bvalid_i SHALL capture (bresp_i!=0) into resp_err_o, clear resp_rdata_o to 0, ->RESP.
REQ-012 RESP: resp_valid_o=1, resp_rdata_o/resp_err_o held; on resp_ready_i ->IDLE; no new request accepted in the same cycle.
REQ-013 Minimum latency, accept to resp_valid_o: read 3 cycles, write 3 cycles (zero-wait slave).
REQ-014 rready_o/bready_o SHALL be 0 outside RD_DATA/WR_RESP; rvalid_i/bvalid_i SHALL be ignored in all other states.
REQ-015 Handshake signals SHALL be registered or decoded only from state/flags; no combinational path from any *_ready_i/*_valid_i input to any *_valid_o output.

Reset
REQ-016 While rst=1 (asynchronous): state=IDLE, aw_done=w_done=0, all *_valid_o/*_ready_o=0 including req_ready_o, resp_rdata_o=0, resp_err_o=0, latched registers=0.
REQ-017 rst asserted mid-transaction SHALL abort it without a response; the first cycle after deassertion is IDLE with req_ready_o=1.

Verification
REQ-018 Read, zero-wait slave: req addr=0xa000_03f8 we=0; slave rdata=0x0000_0000_0000_0041 rresp=0 -> arvalid_o 1 cycle, resp_valid_o 3 cycles after accept, resp_rdata_o=0x41, resp_err_o=0.
REQ-019 Write, awready_i 3 cycles late, wready_i immediate: wdata=0x48 wstrb=0x01 -> wvalid_o drops after 1 cycle, awvalid_o held 4 cycles with stable awaddr_o, bready_o asserted only after both handshakes.
REQ-020 Write, wready_i late, awready_i immediate, bresp_i=2'b10 -> correct ordering and resp_err_o=1, resp_rdata_o=0.
REQ-021 Back-pressure: resp_ready_i low 5 cycles -> resp_valid_o and data held, req_ready_o=0 throughout; IDLE follows the accept cycle.
REQ-022 rst pulse during RD_DATA with rvalid_i never asserted -> all outputs 0 immediately; after release req_ready_o=1 and a new read completes normally.
